// File: rtl/axi_lite_sram.sv
// axi_lite_sram: AXI4-lite slave SRAM, 64-bit data, independent R/W latency.
// Optional SRAM_RAND_DELAY_EN: LFSR picks a 0..7 cycle latency per transaction.
module axi_lite_sram #(
  parameter int unsigned ADDR_W = 12,
  parameter logic [31:0] BASE   = 32'h8000_0000,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned WR_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [63:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [63:0] wdata,
  input  logic [7:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;

  localparam int unsigned TAG_W = 32 - ADDR_W - 3;
  localparam logic [TAG_W-1:0] TAG = BASE[31:ADDR_W+3];
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic [63:0] mem_q [2**ADDR_W];

  logic [3:0] rd_ld;
  logic [3:0] wr_ld;

`ifdef SRAM_RAND_DELAY_EN
  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Fibonacci taps 8,6,5,4
  assign lfsr_d = {lfsr_q[6:0],
                   lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= 8'hA5;
    else      lfsr_q <= lfsr_d;
  end

  assign rd_ld = {1'b0, lfsr_q[2:0]};
  assign wr_ld = {1'b0, lfsr_q[2:0]};
`else
  assign rd_ld = 4'(RD_LAT);
  assign wr_ld = 4'(WR_LAT);
`endif

  logic unused_addr;
  assign unused_addr = ^{araddr[2:0], awaddr[2:0]};

  r_state_e          r_state_q;
  logic [3:0]        r_cnt_q;
  logic [ADDR_W-1:0] r_idx_q;
  logic              r_ok_q;
  logic              arready_q;
  logic              rvalid_q;
  logic [63:0]       rdata_q;
  logic [1:0]        rresp_q;

  logic ar_hs;
  logic ar_ok;
  assign ar_hs = arvalid && arready_q;
  assign ar_ok = araddr[31:ADDR_W+3] == TAG;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
      r_idx_q   <= '0;
      r_ok_q    <= 1'b0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      unique case (r_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            r_idx_q   <= araddr[ADDR_W+2:3];
            r_ok_q    <= ar_ok;
            r_cnt_q   <= rd_ld;
            arready_q <= 1'b0;
            r_state_q <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_cnt_q == 4'd0) begin
            rdata_q   <= r_ok_q ? mem_q[r_idx_q] : 64'd0;
            rresp_q   <= r_ok_q ? OKAY : SLVERR;
            rvalid_q  <= 1'b1;
            r_state_q <= R_RESP;
          end else begin
            r_cnt_q <= r_cnt_q - 4'd1;
          end
        end
        R_RESP: begin
          if (rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  w_state_e          w_state_q;
  logic [3:0]        w_cnt_q;
  logic [ADDR_W-1:0] w_idx_q;
  logic              w_ok_q;
  logic [63:0]       wdata_q;
  logic [7:0]        wstrb_q;
  logic              awready_q;
  logic              wready_q;
  logic              bvalid_q;
  logic [1:0]        bresp_q;

  logic aw_hs;
  logic w_hs;
  logic aw_ok;
  logic mem_we;
  assign aw_hs  = awvalid && awready_q;
  assign w_hs   = wvalid && wready_q;
  assign aw_ok  = awaddr[31:ADDR_W+3] == TAG;
  assign mem_we = (w_state_q == W_WAIT) && (w_cnt_q == 4'd0) && w_ok_q;

  // A dropped ready in W_IDLE marks that channel as already captured
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q <= W_IDLE;
      w_cnt_q   <= '0;
      w_idx_q   <= '0;
      w_ok_q    <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
    end else begin
      unique case (w_state_q)
        W_IDLE: begin
          if (aw_hs) begin
            w_idx_q   <= awaddr[ADDR_W+2:3];
            w_ok_q    <= aw_ok;
            awready_q <= 1'b0;
          end
          if (w_hs) begin
            wdata_q  <= wdata;
            wstrb_q  <= wstrb;
            wready_q <= 1'b0;
          end
          if ((aw_hs || !awready_q) && (w_hs || !wready_q)) begin
            w_cnt_q   <= wr_ld;
            w_state_q <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (w_cnt_q == 4'd0) begin
            bresp_q   <= w_ok_q ? OKAY : SLVERR;
            bvalid_q  <= 1'b1;
            w_state_q <= W_RESP;
          end else begin
            w_cnt_q <= w_cnt_q - 4'd1;
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Array is never reset; a read sampling this edge sees the old word
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 8; i++) begin
        if (wstrb_q[i]) mem_q[w_idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;

endmodule

// File: tb/tb_axi_lite_sram.sv
// tb_axi_lite_sram: directed self-checking bench for axi_lite_sram.
// Default build: ADDR_W=12, BASE=0x8000_0000, RD_LAT=WR_LAT=1.
module tb_axi_lite_sram;

  logic        clk;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int errors = 0;
  int checks = 0;

  axi_lite_sram dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic axi_read(input logic [31:0] a, output logic [63:0] d,
                          output logic [1:0] r, output int lat);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1; arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 50) begin @(posedge clk); #1; lat++; end
    checks++;
    if (rvalid !== 1'b1) begin
      errors++;
      $display("FAIL rd_timeout addr=%h rvalid=%b required 1", a, rvalid);
    end
    d = rdata; r = rresp;
    rready = 1'b1; @(posedge clk); #1; rready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [63:0] d,
                           input logic [7:0] s, output logic [1:0] r,
                           output int lat);
    int n;
    logic ah, wh;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; n = 0;
    while ((awvalid || wvalid) && n < 50) begin
      ah = awvalid && awready; wh = wvalid && wready;
      @(posedge clk); #1;
      if (ah) awvalid = 1'b0;
      if (wh) wvalid = 1'b0;
      n++;
    end
    lat = 0;
    while (!bvalid && lat < 50) begin @(posedge clk); #1; lat++; end
    checks++;
    if (bvalid !== 1'b1) begin
      errors++;
      $display("FAIL wr_timeout addr=%h bvalid=%b required 1", a, bvalid);
    end
    r = bresp;
    bready = 1'b1; @(posedge clk); #1; bready = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] o;
    #1;
    o = {arready, awready, wready, rvalid, bvalid, |rresp};
    checks++;
    if (o !== 6'b111000) begin
      errors++; $display("FAIL reset_ctrl got=%b required 111000", o);
    end
    checks++;
    if (rdata !== 64'd0 || bresp !== 2'b00) begin
      errors++;
      $display("FAIL reset_data rdata=%h bresp=%b required 0/00", rdata, bresp);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    o = {arready, awready, wready, rvalid, bvalid, 1'b0};
    checks++;
    if (o !== 6'b111000) begin
      errors++; $display("FAIL post_reset_idle got=%b required 111000", o);
    end
  endtask

  task automatic test_full_rw();
    logic [63:0] d; logic [1:0] r; int lat;
    axi_write(32'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, r, lat);
    checks++;
    if (r !== 2'b00 || lat != 2) begin
      errors++; $display("FAIL full_wr bresp=%b lat=%0d required 00/2", r, lat);
    end
    axi_read(32'h8000_0010, d, r, lat);
    checks++;
    if (d !== 64'h1122_3344_5566_7788 || r !== 2'b00 || lat != 2) begin
      errors++;
      $display("FAIL full_rd data=%h resp=%b lat=%0d required 1122334455667788/00/2",
               d, r, lat);
    end
    axi_read(32'h8000_0015, d, r, lat);
    checks++;
    if (d !== 64'h1122_3344_5566_7788 || r !== 2'b00) begin
      errors++; $display("FAIL low_bits_ignored data=%h resp=%b", d, r);
    end
  endtask

  task automatic test_partial_strobe();
    logic [63:0] d; logic [1:0] r; int lat;
    axi_write(32'h8000_0010, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, r, lat);
    axi_read(32'h8000_0010, d, r, lat);
    checks++;
    if (d !== 64'h1122_3344_BBBB_BBBB) begin
      errors++; $display("FAIL strb_0f data=%h required 11223344bbbbbbbb", d);
    end
    axi_write(32'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, r, lat);
    checks++;
    if (r !== 2'b00) begin
      errors++; $display("FAIL strb_00_resp bresp=%b required 00", r);
    end
    axi_read(32'h8000_0010, d, r, lat);
    checks++;
    if (d !== 64'h1122_3344_BBBB_BBBB) begin
      errors++; $display("FAIL strb_00_data data=%h required 11223344bbbbbbbb", d);
    end
    axi_write(32'h8000_0010, 64'h0000_00C0_0000_0000, 8'h10, r, lat);
    axi_read(32'h8000_0010, d, r, lat);
    checks++;
    if (d !== 64'h1122_33C0_BBBB_BBBB) begin
      errors++; $display("FAIL strb_10 data=%h required 112233c0bbbbbbbb", d);
    end
  endtask

  task automatic test_out_of_range();
    logic [63:0] d; logic [1:0] r; int lat;
    axi_write(32'h8000_0000, 64'hDEAD_BEEF_0123_4567, 8'hFF, r, lat);
    axi_read(32'h1000_0000, d, r, lat);
    checks++;
    if (d !== 64'd0 || r !== 2'b10) begin
      errors++; $display("FAIL oor_rd data=%h resp=%b required 0/10", d, r);
    end
    axi_write(32'h1000_0000, 64'h5555_5555_5555_5555, 8'hFF, r, lat);
    checks++;
    if (r !== 2'b10) begin
      errors++; $display("FAIL oor_wr bresp=%b required 10", r);
    end
    axi_read(32'h8000_0000, d, r, lat);
    checks++;
    if (d !== 64'hDEAD_BEEF_0123_4567 || r !== 2'b00) begin
      errors++; $display("FAIL oor_wr_nochange data=%h resp=%b", d, r);
    end
    axi_write(32'h8000_7FF8, 64'h0BAD_F00D_CAFE_0001, 8'hFF, r, lat);
    axi_read(32'h8000_7FF8, d, r, lat);
    checks++;
    if (d !== 64'h0BAD_F00D_CAFE_0001 || r !== 2'b00) begin
      errors++; $display("FAIL last_word data=%h resp=%b", d, r);
    end
    axi_read(32'h8000_8000, d, r, lat);
    checks++;
    if (d !== 64'd0 || r !== 2'b10) begin
      errors++; $display("FAIL past_end data=%h resp=%b required 0/10", d, r);
    end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    araddr = 32'h8000_0010; arvalid = 1'b1;
    @(posedge clk); #1; arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rvalid !== 1'b1 || rdata !== 64'h1122_33C0_BBBB_BBBB ||
          rresp !== 2'b00 || arready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d rvalid=%b rdata=%h rresp=%b arready=%b",
                 i, rvalid, rdata, rresp, arready);
      end
    end
    rready = 1'b1;
    @(posedge clk); #1; rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release rvalid=%b arready=%b required 0/1", rvalid, arready);
    end
  endtask

  task automatic test_split_write();
    logic [63:0] d; logic [1:0] r; int lat;
    @(negedge clk);
    awaddr = 32'h8000_0040; awvalid = 1'b1;
    @(posedge clk); #1; awvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (awready !== 1'b0 || wready !== 1'b1 || bvalid !== 1'b0) begin
        errors++;
        $display("FAIL split_gap cyc=%0d awready=%b wready=%b bvalid=%b", i,
                 awready, wready, bvalid);
      end
    end
    wdata = 64'h0102_0304_0506_0708; wstrb = 8'hFF; wvalid = 1'b1;
    @(posedge clk); #1; wvalid = 1'b0;
    lat = 0;
    while (!bvalid && lat < 50) begin @(posedge clk); #1; lat++; end
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || lat != 2) begin
      errors++;
      $display("FAIL split_bvalid bvalid=%b bresp=%b lat=%0d required 1/00/2",
               bvalid, bresp, lat);
    end
    bready = 1'b1; @(posedge clk); #1; bready = 1'b0;
    axi_read(32'h8000_0040, d, r, lat);
    checks++;
    if (d !== 64'h0102_0304_0506_0708) begin
      errors++; $display("FAIL split_data data=%h required 0102030405060708", d);
    end
  endtask

  task automatic test_collision();
    logic [63:0] d; logic [1:0] r; int lat; int n;
    axi_write(32'h8000_0020, 64'h0000_0000_1111_1111, 8'hFF, r, lat);
    @(negedge clk);
    araddr = 32'h8000_0020; arvalid = 1'b1;
    awaddr = 32'h8000_0020; awvalid = 1'b1;
    wdata = 64'h2222_2222_2222_2222; wstrb = 8'hFF; wvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!(rvalid && bvalid) && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (rvalid !== 1'b1 || bvalid !== 1'b1 || rdata !== 64'h0000_0000_1111_1111) begin
      errors++;
      $display("FAIL collision_old rvalid=%b bvalid=%b rdata=%h required 1/1/0000000011111111",
               rvalid, bvalid, rdata);
    end
    rready = 1'b1; bready = 1'b1;
    @(posedge clk); #1; rready = 1'b0; bready = 1'b0;
    axi_read(32'h8000_0020, d, r, lat);
    checks++;
    if (d !== 64'h2222_2222_2222_2222) begin
      errors++; $display("FAIL collision_new data=%h required 2222222222222222", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] d; logic [1:0] r; int lat;
    logic [4:0] o;
    @(negedge clk);
    araddr = 32'h8000_0010; arvalid = 1'b1;
    awaddr = 32'h8000_0000; awvalid = 1'b1;
    wdata = 64'hFFFF_0000_FFFF_0000; wstrb = 8'hFF; wvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    rst = 1'b0;
    #1;
    o = {arready, awready, wready, rvalid, bvalid};
    checks++;
    if (o !== 5'b11100 || rdata !== 64'd0 || rresp !== 2'b00 || bresp !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_out ctrl=%b rdata=%h rresp=%b bresp=%b", o, rdata,
               rresp, bresp);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    axi_read(32'h8000_0000, d, r, lat);
    checks++;
    if (d !== 64'hDEAD_BEEF_0123_4567 || r !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_nocommit data=%h required deadbeef01234567", d);
    end
    axi_write(32'h8000_0008, 64'h7777_6666_5555_4444, 8'hFF, r, lat);
    axi_read(32'h8000_0008, d, r, lat);
    checks++;
    if (d !== 64'h7777_6666_5555_4444 || r !== 2'b00 || lat != 2) begin
      errors++;
      $display("FAIL post_reset_rw data=%h resp=%b lat=%0d", d, r, lat);
    end
  endtask

  initial begin
    rst = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    test_full_rw();
    test_partial_strobe();
    test_out_of_range();
    test_backpressure();
    test_split_write();
    test_collision();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_sram.md
Name: axi_lite_sram

Overview:
- Slave-side memory model on the single AXI4-lite port driven by the CPU bus arbiter.
- Serves instruction fetches and load/store traffic: 32-bit address, 64-bit data, byte write strobes.
- Read and write channels are independent, each with a configurable response latency, so the arbiter and LSU handshakes see multi-cycle memory.
- Sits directly downstream of the arbiter; no other masters.

Parameters:
ADDR_W, 12, word-index width; array holds 2^ADDR_W 64-bit words.
BASE, 32'h8000_0000, base address of the array; must be aligned to 2^(ADDR_W+3).
RD_LAT, 1, wait cycles between AR handshake and rvalid (0..15).
WR_LAT, 1, wait cycles between capture of both AW and W and bvalid (0..15).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
araddr  input  32  read address.
arvalid  input  1  read address valid.
arready  output  1  read address ready.
rdata  output  64  read data.
rresp  output  2  read response: 00 OKAY, 10 SLVERR.
rvalid  output  1  read data valid.
rready  input  1  master ready for read data.
awaddr  input  32  write address.
awvalid  input  1  write address valid.
awready  output  1  write address ready.
wdata  input  64  write data.
wstrb  input  8  byte strobes; bit i enables wdata[8i+7:8i].
wvalid  input  1  write data valid.
wready  output  1  write data ready.
bresp  output  2  write response: 00 OKAY, 10 SLVERR.
bvalid  output  1  write response valid.
bready  input  1  master ready for write response.

Behaviour:
- Reset (rst low, asynchronous): both FSMs go to IDLE. arready=1, awready=1, wready=1; rvalid=0, bvalid=0; rdata=0, rresp=0, bresp=0. Array contents are not reset. Any in-flight write is dropped without committing.
- Address decode: word index = addr[ADDR_W+2:3]. addr[2:0] is ignored. The address is in range when addr[31:ADDR_W+3] == BASE[31:ADDR_W+3]; otherwise it is an error.
- Read FSM states: R_IDLE, R_WAIT, R_RESP.
  - R_IDLE: arready=1. On arvalid&arready, latch the address, load cnt=RD_LAT, go to R_WAIT.
  - R_WAIT: arready=0. If cnt==0, sample the array into rdata, set rresp, assert rvalid, go to R_RESP. Otherwise decrement cnt.
  - Timing: AR handshake at edge N gives rvalid high after edge N+1+RD_LAT.
  - R_RESP: rvalid, rdata and rresp are held stable until rready. On rvalid&rready, deassert rvalid and return to R_IDLE; arready is 1 the following cycle. No back-to-back acceptance in the same cycle.
  - Read error: rdata=0, rresp=2'b10.
- Write FSM states: W_IDLE, W_WAIT, W_RESP.
  - W_IDLE: AW and W are captured independently. awready drops the cycle after the AW handshake; wready drops the cycle after the W handshake. Both channels may complete in the same cycle, in either order, or with any gap.
  - When both are captured, load cnt=WR_LAT and go to W_WAIT.
  - W_WAIT: at cnt==0, commit the byte-masked write (in range only), set bresp, assert bvalid, go to W_RESP. Otherwise decrement cnt.
  - W_RESP: bvalid and bresp are held until bready. On the handshake, return to W_IDLE with awready=1 and wready=1.
  - Write error: the array is unchanged, bresp=2'b10. wstrb=0 on an in-range address is OKAY with no array change.
- Read/write collision: if a read samples the array on the same edge that a write commits to the same word, the read returns the pre-write data. The array write takes effect on that edge.
- No outstanding-transaction queueing: at most one read and one write in flight.

Optional Feature:
SRAM_RAND_DELAY_EN
- Defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4) is added, seeded 8'hA5 on reset, advancing every cycle. Each accepted read or write loads cnt from lfsr[2:0] instead of RD_LAT/WR_LAT, giving 0..7 wait cycles. This stresses arbiter and LSU handshakes.
- Undefined: no LFSR logic; latencies are exactly RD_LAT and WR_LAT.

Test Plan:
- Full write then read: AW+W at 0x8000_0010, wdata 0x1122_3344_5566_7788, wstrb 0xFF, same cycle -> bvalid after WR_LAT+1 cycles with bresp 00. AR at 0x8000_0010 -> rdata 0x1122_3344_5566_7788, rresp 00, rvalid exactly RD_LAT+1 cycles after the AR handshake.
- Partial strobe: over the word above, write 0xAAAA_AAAA_BBBB_BBBB with wstrb 0x0F -> read returns 0x1122_3344_BBBB_BBBB.
- Out of range: read at 0x1000_0000 -> rdata 0, rresp 10. Write at 0x1000_0000 -> bresp 10, and a subsequent read of 0x8000_0000 is unchanged.
- Backpressure: hold rready low 5 cycles after rvalid -> rvalid, rdata and rresp stable, arready 0 throughout. Raise rready -> next cycle rvalid 0, arready 1.
- Split write channels: AW valid 3 cycles before W -> awready low after the AW handshake, no commit until the W handshake, bvalid WR_LAT+1 cycles after the W handshake, data correct.
- Reset mid-transaction: assert rst during R_WAIT and W_WAIT -> outputs at reset values immediately, pending write not committed (a read after reset returns the old word), normal operation afterwards.
